// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES-128 <-> UART message packer/unpacker pair.
// Holds the unpacker FSM state encodings, block geometry and the byte/word
// widths both sides agree on.
package aes_uart_pkg;

  localparam int BYTE_W      = 8;
  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 4;
  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_W     = BLOCK_WORDS * WORD_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_LOAD    = 3'd2,
    S_WAIT    = 3'd3,
    S_CLEANUP = 3'd4
  } state_t;

endpackage

// File: rtl/mp_out.sv
// mp_out: collects one 128-bit AES result block as four 32-bit words, then
// streams it to the UART transmitter most-significant byte first.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   core_data_in    : result word from the core (word 0 = block bits [127:96])
//   core_dv_in      : core_data_in valid this cycle
//   tx_busy_in      : UART TX is shifting a byte
//   tx_done_in      : one-cycle pulse, UART TX finished the current byte
//   tx_byte_out     : byte to transmit (registered)
//   tx_dv_out       : one-cycle start pulse to UART TX (registered)
//   mp_ready_out    : block is accepting core words
//   mp_done_out     : one-cycle pulse after the 16th byte completes
//   state_dbg       : current FSM state, for observation only
//
// Handshakes
//   Core side: a word is taken on any edge where core_dv_in=1 and
//   mp_ready_out=1; a word offered while mp_ready_out=0 is dropped, so the
//   core must hold off. UART side: tx_dv_out pulses once per byte with
//   tx_byte_out valid and held until the next pulse; only a tx_done_in seen
//   in S_WAIT after the pulse cycle advances to the next byte.
module mp_out
  import aes_uart_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] core_data_in,
  input  logic                  core_dv_in,
  input  logic                  tx_busy_in,
  input  logic                  tx_done_in,
  output logic [BYTE_W-1:0]     tx_byte_out,
  output logic                  tx_dv_out,
  output logic                  mp_ready_out,
  output logic                  mp_done_out,
  output state_t                state_dbg
);

  localparam int BUF_W = DATA_WIDTH * BLOCK_WORDS;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         word_cnt;
  logic [3:0]         byte_cnt;
  logic [BUF_W-1:0]   buffer;
  logic               done_ok;
  logic               last_word;
  logic               last_byte;

  // A done pulse landing in the same cycle as our own start pulse belongs to
  // the previous byte's timing window, so it is not counted.
  assign done_ok   = tx_done_in && !tx_dv_out;
  assign last_word = (word_cnt == 2'(BLOCK_WORDS - 1));
  assign last_byte = (byte_cnt == 4'(BLOCK_BYTES - 1));

  assign mp_ready_out = (state == S_IDLE) || (state == S_COLLECT);
  assign state_dbg    = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (core_dv_in) state_nxt = S_COLLECT;
      S_COLLECT: if (core_dv_in && last_word) state_nxt = S_LOAD;
      S_LOAD:    if (!tx_busy_in) state_nxt = S_WAIT;
      S_WAIT:    if (done_ok) state_nxt = last_byte ? S_CLEANUP : S_LOAD;
      S_CLEANUP: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt    <= '0;
      byte_cnt    <= '0;
      buffer      <= '0;
      tx_byte_out <= '0;
      tx_dv_out   <= 1'b0;
      mp_done_out <= 1'b0;
    end else begin
      tx_dv_out   <= 1'b0;
      mp_done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (core_dv_in) begin
            buffer[BUF_W-1 -: DATA_WIDTH] <= core_data_in;
            word_cnt <= 2'd1;
          end
        end
        S_COLLECT: begin
          if (core_dv_in) begin
            buffer[BUF_W-1 - DATA_WIDTH*int'(word_cnt) -: DATA_WIDTH] <= core_data_in;
            // The final word leaves word_cnt at 3; cleanup clears it, so the
            // counter never wraps inside a block.
            if (last_word) byte_cnt <= '0;
            else           word_cnt <= word_cnt + 2'd1;
          end
        end
        S_LOAD: begin
          if (!tx_busy_in) begin
            tx_byte_out <= buffer[BUF_W-1 - BYTE_W*int'(byte_cnt) -: BYTE_W];
            tx_dv_out   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (done_ok) begin
            // mp_done_out is raised on entry to cleanup so it is visible
            // while the FSM sits in S_CLEANUP.
            if (last_byte) mp_done_out <= 1'b1;
            else           byte_cnt    <= byte_cnt + 4'd1;
          end
        end
        S_CLEANUP: begin
          word_cnt <= '0;
          byte_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_out.sv
// Directed bench for mp_out: byte stream order, handshake timing, stalls,
// dropped words, mid-block reset and spurious done pulses.
module tb_mp_out;
  import aes_uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_data_in;
  logic        core_dv_in;
  logic        tx_busy_in;
  logic        tx_done_in;
  logic [7:0]  tx_byte_out;
  logic        tx_dv_out;
  logic        mp_ready_out;
  logic        mp_done_out;
  state_t      state_dbg;

  always #5 clk = ~clk;

  mp_out #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_data_in (core_data_in),
    .core_dv_in   (core_dv_in),
    .tx_busy_in   (tx_busy_in),
    .tx_done_in   (tx_done_in),
    .tx_byte_out  (tx_byte_out),
    .tx_dv_out    (tx_dv_out),
    .mp_ready_out (mp_ready_out),
    .mp_done_out  (mp_done_out),
    .state_dbg    (state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int dv_count = 0;
  int done_count = 0;
  logic [7:0] exp_q[$];

  logic [31:0] blk_words [2][4] = '{
    '{32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a},
    '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff}
  };
  logic [7:0] blk_bytes [2][16] = '{
    '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
      8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a},
    '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
      8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff}
  };

  // Pulse monitors sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (tx_dv_out)   dv_count++;
    if (mp_done_out) done_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input int sel);
    for (int i = 0; i < 16; i++) exp_q.push_back(blk_bytes[sel][i]);
  endtask

  task automatic send_words(input int sel, input int gap);
    for (int i = 0; i < 4; i++) begin
      core_data_in = blk_words[sel][i];
      core_dv_in   = 1'b1;
      tick();
      core_dv_in   = 1'b0;
      if (i < 3) begin
        chk("ready_after_word", 32'(mp_ready_out), 32'd1);
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("ready_in_gap", 32'(mp_ready_out), 32'd1);
        end
      end
    end
    chk("state_load", 32'(state_dbg), 32'(S_LOAD));
    chk("ready_low", 32'(mp_ready_out), 32'd0);
  endtask

  task automatic wait_dv(output int cyc);
    bit found;
    found = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cyc++;
      if (tx_dv_out) begin
        found = 1'b1;
        break;
      end
    end
    chk("dv_seen", 32'(found), 32'd1);
  endtask

  // Waits for a start pulse, checks it, then answers with tx_done_in ~10
  // cycles later. junk injects a dropped core word; early_done raises
  // tx_done_in in the pulse cycle, which must be ignored.
  task automatic serve_byte(input int exp_cyc, input bit junk, input bit early_done);
    int cyc;
    logic [7:0] exp_b;
    logic [7:0] held;
    wait_dv(cyc);
    if (exp_cyc > 0) chk("dv_latency", 32'(cyc), 32'(exp_cyc));
    exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk("tx_byte", 32'(tx_byte_out), 32'(exp_b));
    held = tx_byte_out;
    if (early_done) tx_done_in = 1'b1;
    tick();
    tx_done_in = 1'b0;
    chk("dv_width", 32'(tx_dv_out), 32'd0);
    chk("state_wait", 32'(state_dbg), 32'(S_WAIT));
    if (junk) begin
      core_data_in = 32'hdeadbeef;
      core_dv_in   = 1'b1;
      tick();
      core_dv_in   = 1'b0;
      chk("junk_ready", 32'(mp_ready_out), 32'd0);
      repeat (7) tick();
    end else begin
      repeat (8) tick();
    end
    chk("byte_stable", 32'(tx_byte_out), 32'(held));
    tx_done_in = 1'b1;
    tick();
    tx_done_in = 1'b0;
  endtask

  task automatic end_block();
    chk("mp_done_pulse", 32'(mp_done_out), 32'd1);
    chk("state_cleanup", 32'(state_dbg), 32'(S_CLEANUP));
    chk("ready_cleanup", 32'(mp_ready_out), 32'd0);
    tick();
    chk("mp_done_clear", 32'(mp_done_out), 32'd0);
    chk("ready_back", 32'(mp_ready_out), 32'd1);
    chk("state_idle", 32'(state_dbg), 32'(S_IDLE));
  endtask

  task automatic run_block(input int sel, input int gap, input bit junk, input bit early);
    push_exp(sel);
    send_words(sel, gap);
    for (int i = 0; i < 16; i++) serve_byte(1, junk, early);
    end_block();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dv_snap;
    rst = 1'b1;
    core_data_in = '0;
    core_dv_in = 1'b0;
    tx_busy_in = 1'b0;
    tx_done_in = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_tx_dv", 32'(tx_dv_out), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte_out), 32'd0);
    chk("rst_mp_done", 32'(mp_done_out), 32'd0);
    chk("rst_ready", 32'(mp_ready_out), 32'd1);
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(mp_ready_out), 32'd1);

    // Spurious done in idle
    tx_done_in = 1'b1;
    tick();
    tx_done_in = 1'b0;
    chk("idle_done_ignored", 32'(state_dbg), 32'(S_IDLE));
    tick();

    // Back-to-back words, then words with 3-cycle gaps and early done pulses
    run_block(0, 0, 1'b0, 1'b0);
    run_block(0, 3, 1'b0, 1'b1);

    // tx_busy_in stall on entry to S_LOAD, with a spurious done mid-stall
    push_exp(0);
    tx_busy_in = 1'b1;
    send_words(0, 0);
    dv_snap = dv_count;
    for (int i = 0; i < 20; i++) begin
      tx_done_in = (i == 10);
      tick();
    end
    tx_done_in = 1'b0;
    chk("stall_state", 32'(state_dbg), 32'(S_LOAD));
    chk("stall_no_dv", 32'(dv_count), 32'(dv_snap));
    tx_busy_in = 1'b0;
    for (int i = 0; i < 16; i++) serve_byte(1, 1'b0, 1'b0);
    end_block();

    // Dropped word during S_WAIT, then a clean second block
    run_block(0, 0, 1'b1, 1'b0);
    run_block(1, 0, 1'b0, 1'b0);

    // Reset after byte 5
    push_exp(0);
    send_words(0, 0);
    for (int i = 0; i < 6; i++) serve_byte(1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_tx_dv", 32'(tx_dv_out), 32'd0);
    chk("abort_tx_byte", 32'(tx_byte_out), 32'd0);
    chk("abort_mp_done", 32'(mp_done_out), 32'd0);
    chk("abort_state", 32'(state_dbg), 32'(S_IDLE));
    chk("abort_ready", 32'(mp_ready_out), 32'd1);
    exp_q.delete();
    dv_snap = dv_count;
    repeat (30) tick();
    chk("abort_no_dv", 32'(dv_count), 32'(dv_snap));
    run_block(1, 0, 1'b0, 1'b0);

    // Totals: 16*5 full blocks + 6 aborted + 16 after abort
    chk("dv_total", 32'(dv_count), 32'd102);
    chk("done_total", 32'(done_count), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
